// File: rtl/spi_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one SPI master.
// A transfer that stalls longer than TMO cycles is aborted with an err pulse.
module spi_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 16,
  parameter int TMO   = 64
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic                spi_start,
  output logic [DW-1:0]       spi_d_in,
  input  logic                spi_read_en,
  input  logic                spi_cs,
  output logic                busy,
  output logic                err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = ($clog2(TMO) + 1 > 7) ? $clog2(TMO) + 1 : 7;

  typedef enum logic [2:0] {IDLE, START, WAIT_CS, WAIT_END, DONE} state_t;

  state_t            state, state_nx;
  logic [IW-1:0]     last_win, win_idx, win_next, cand;
  logic [IW-1:0]     last_d, widx_d;
  logic              win_found;
  logic [CW-1:0]     cnt, cnt_d;
  logic              tmo_hit;
  logic [N_REQ-1:0]  gnt_d, done_d;
  logic              start_d, err_d, busy_d;
  logic [DW-1:0]     d_in_d;

  // Search starts just after the last winner, so a finished requester drops to lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_next  = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last_win) + k) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_next  = cand;
      end
    end
  end

  // The counter runs from START entry, so tmo_hit marks the TMO-th cycle of the transfer.
  assign tmo_hit = (cnt == CW'(TMO - 1));

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (win_found && spi_read_en) state_nx = START;
      START:    state_nx = WAIT_CS;
      WAIT_CS:  if (tmo_hit) state_nx = IDLE;
                else if (!spi_cs) state_nx = WAIT_END;
      WAIT_END: if (tmo_hit) state_nx = IDLE;
                else if (spi_cs && spi_read_en) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = gnt;
    done_d  = '0;
    start_d = 1'b0;
    err_d   = 1'b0;
    d_in_d  = spi_d_in;
    cnt_d   = cnt;
    last_d  = last_win;
    widx_d  = win_idx;
    busy_d  = (state_nx != IDLE);
    case (state)
      IDLE: begin
        gnt_d = '0;
        if (win_found && spi_read_en) begin
          gnt_d   = N_REQ'(1) << win_next;
          d_in_d  = req_data[int'(win_next)*DW +: DW];
          start_d = 1'b1;
          cnt_d   = '0;
          widx_d  = win_next;
        end
      end
      START: cnt_d = cnt + CW'(1);
      WAIT_CS, WAIT_END: begin
        if (tmo_hit || state_nx == DONE) begin
          done_d = gnt;
          gnt_d  = '0;
          last_d = win_idx;
          err_d  = tmo_hit;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      gnt       <= '0;
      done      <= '0;
      spi_start <= 1'b0;
      spi_d_in  <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
      last_win  <= IW'(N_REQ - 1);
      win_idx   <= '0;
    end else begin
      gnt       <= gnt_d;
      done      <= done_d;
      spi_start <= start_d;
      spi_d_in  <= d_in_d;
      busy      <= busy_d;
      err       <= err_d;
      cnt       <= cnt_d;
      last_win  <= last_d;
      win_idx   <= widx_d;
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: expected grants/completions are queued by the
// stimulus and popped by a monitor whenever the DUT strobes spi_start or done.
module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] w [4];
  logic [63:0] req_data;
  logic [3:0]  gnt, done;
  logic        spi_start, busy, err;
  logic [15:0] spi_d_in;
  logic        spi_read_en;
  logic        spi_cs = 1'b1;
  logic        m_ren = 1'b1;
  logic        ren_block = 1'b0;
  logic        cs_stuck = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {logic [3:0] g; logic [15:0] d; logic e;} exp_t;
  exp_t gq[$];
  exp_t dq[$];

  assign req_data    = {w[3], w[2], w[1], w[0]};
  assign spi_read_en = m_ren & ~ren_block;

  spi_arbiter #(.N_REQ(4), .DW(16), .TMO(64)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .spi_start(spi_start), .spi_d_in(spi_d_in),
    .spi_read_en(spi_read_en), .spi_cs(spi_cs), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // SPI master model: after a start, chip select drops for a 16-bit shift.
  always begin
    @(negedge clk);
    if (spi_start && !cs_stuck) begin
      @(negedge clk);
      spi_cs = 1'b0;
      m_ren  = 1'b0;
      repeat (16) @(negedge clk);
      spi_cs = 1'b1;
      m_ren  = 1'b1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
      if (spi_start) begin
        if (gq.size() == 0) chk("unexpected_start", {28'd0, gnt}, 32'd0);
        else begin
          e = gq.pop_front();
          chk("grant_gnt", {28'd0, gnt}, {28'd0, e.g});
          chk("grant_data", {16'd0, spi_d_in}, {16'd0, e.d});
        end
      end
      if (done != '0 || err) begin
        if (dq.size() == 0) chk("unexpected_done", {27'd0, err, done}, 32'd0);
        else begin
          e = dq.pop_front();
          chk("done_vec", {28'd0, done}, {28'd0, e.g});
          chk("done_err", {31'd0, err}, {31'd0, e.e});
          chk("done_data_held", {16'd0, spi_d_in}, {16'd0, e.d});
        end
      end
    end
  end

  task automatic push(input logic [3:0] g, input logic [15:0] d, input logic e, input bit with_done);
    exp_t x;
    x.g = g; x.d = d; x.e = e;
    gq.push_back(x);
    if (with_done) dq.push_back(x);
  endtask

  task automatic wait_start(output int c);
    bit ok = 0;
    c = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (spi_start) begin c = cyc; ok = 1; break; end
    end
    chk("start_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_done(output int c);
    bit ok = 0;
    c = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done != '0) begin c = cyc; ok = 1; break; end
    end
    chk("done_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_cs(input logic lvl);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (spi_cs == lvl) begin ok = 1; break; end
    end
    chk("cs_level", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_master_idle();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_ren && spi_cs && !busy) begin ok = 1; break; end
    end
    chk("master_idle", {31'd0, ok}, 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_gnt"}, {28'd0, gnt}, 32'd0);
    chk({tag, "_done"}, {28'd0, done}, 32'd0);
    chk({tag, "_start"}, {31'd0, spi_start}, 32'd0);
    chk({tag, "_d_in"}, {16'd0, spi_d_in}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int c0, c1;
    w[0] = 16'h0F0F; w[1] = 16'h1111; w[2] = 16'hA5C3; w[3] = 16'h3333;

    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Single requester 2.
    push(4'b0100, 16'hA5C3, 1'b0, 1);
    @(negedge clk);
    req = 4'b0100;
    @(posedge clk);
    #1;
    chk("s1_start_latency", {31'd0, spi_start}, 32'd1);
    chk("s1_gnt", {28'd0, gnt}, 32'h4);
    chk("s1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    w[2] = 16'hFFFF;
    wait_cs(1'b0);
    wait_cs(1'b1);
    #1 chk("s1_done_latency", {28'd0, done}, 32'h4);
    @(negedge clk);
    req = 4'b0000;
    w[2] = 16'hA5C3;
    wait_master_idle();

    // Round robin with all requesters held after reset.
    do_reset();
    push(4'b0001, 16'h0F0F, 1'b0, 1);
    push(4'b0010, 16'h1111, 1'b0, 1);
    push(4'b0100, 16'hA5C3, 1'b0, 1);
    push(4'b1000, 16'h3333, 1'b0, 1);
    push(4'b0001, 16'h0F0F, 1'b0, 1);
    @(negedge clk);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_done(c1);
    req = 4'b0000;
    wait_master_idle();

    // Requester 1 drops its request mid-transfer.
    push(4'b0010, 16'h1111, 1'b0, 1);
    @(negedge clk);
    req = 4'b0010;
    wait_cs(1'b0);
    repeat (3) @(negedge clk);
    req = 4'b0000;
    wait_done(c1);
    wait_master_idle();

    // Chip select never drops: timeout abort.
    cs_stuck = 1'b1;
    push(4'b0010, 16'h1111, 1'b1, 1);
    @(negedge clk);
    req = 4'b0010;
    wait_start(c0);
    wait_done(c1);
    req = 4'b0000;
    chk("tmo_latency", 32'(c1 - c0), 32'd64);
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("tmo_err_clear", {31'd0, err}, 32'd0);
    chk("tmo_done_clear", {28'd0, done}, 32'd0);
    cs_stuck = 1'b0;
    wait_master_idle();

    // Reset in the middle of a transfer.
    push(4'b0001, 16'h0F0F, 1'b0, 0);
    @(negedge clk);
    req = 4'b0001;
    wait_start(c0);
    wait_cs(1'b0);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    req = 4'b0000;
    @(posedge clk);
    #1 check_zero_outputs("midrst");
    @(negedge clk);
    rstn = 1'b1;
    wait_master_idle();
    push(4'b1000, 16'h3333, 1'b0, 1);
    req = 4'b1000;
    @(posedge clk);
    #1 chk("midrst_gnt3", {28'd0, gnt}, 32'h8);
    wait_done(c1);
    req = 4'b0000;
    wait_master_idle();

    // Master not ready: no grant until spi_read_en rises.
    push(4'b0001, 16'h0F0F, 1'b0, 1);
    ren_block = 1'b1;
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("noren_gnt", {28'd0, gnt}, 32'd0);
      chk("noren_busy", {31'd0, busy}, 32'd0);
    end
    @(negedge clk);
    ren_block = 1'b0;
    @(posedge clk);
    #1;
    chk("ren_start", {31'd0, spi_start}, 32'd1);
    chk("ren_gnt", {28'd0, gnt}, 32'h1);
    wait_done(c1);
    req = 4'b0000;
    wait_master_idle();

    repeat (3) @(negedge clk);
    chk("grant_queue_empty", 32'(gq.size()), 32'd0);
    chk("done_queue_empty", 32'(dq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
